// File: rtl/simple_bus_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : simple_bus_rr_arb
// Brief    : Round-robin arbiter sharing one simple-bus slave among N_MST
//            masters, with valid/ack handshake and slave timeout.
// Revision : 1.0
// ============================================================================
module simple_bus_rr_arb #(
    parameter int N_MST          = 2,
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8,
    parameter int TIMEOUT_CYC    = 15
) (
    input  logic                               i_clk,
    input  logic                               i_async_rst_n,
    input  logic [N_MST-1:0]                   i_mst_req,
    input  logic [N_MST-1:0]                   i_mst_we,
    input  logic [N_MST*ADDR_BIT_WIDTH-1:0]    i_mst_addr,
    input  logic [N_MST*DATA_BIT_WIDTH-1:0]    i_mst_wr_data,
    output logic [N_MST-1:0]                   o_mst_gnt,
    output logic [N_MST-1:0]                   o_mst_rsp_vld,
    output logic                               o_mst_rsp_err,
    output logic [DATA_BIT_WIDTH-1:0]          o_mst_rd_data,
    output logic                               o_slv_req,
    output logic                               o_slv_we,
    output logic [ADDR_BIT_WIDTH-1:0]          o_slv_addr,
    output logic [DATA_BIT_WIDTH-1:0]          o_slv_wr_data,
    input  logic                               i_slv_ack,
    input  logic [DATA_BIT_WIDTH-1:0]          i_slv_rd_data
);

    localparam int c_ptr_w = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int c_cnt_w = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [c_ptr_w-1:0] c_last_mst   = c_ptr_w'(N_MST - 1);
    localparam logic [c_ptr_w:0]   c_n_mst_ext  = (c_ptr_w + 1)'(N_MST);
    localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(TIMEOUT_CYC);
    localparam logic               c_timeout_en = (TIMEOUT_CYC > 0);
    localparam logic [N_MST-1:0]   c_one        = N_MST'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                      r_state;
    logic [1:0]                  r_rst_sync;
    logic                        w_rst_n;
    logic [c_ptr_w-1:0]          r_ptr;
    logic [c_ptr_w-1:0]          r_sel;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [N_MST-1:0]            r_gnt;
    logic [N_MST-1:0]            r_rsp_vld;
    logic                        r_rsp_err;
    logic [DATA_BIT_WIDTH-1:0]   r_rsp_data;
    logic                        r_slv_req;
    logic                        r_slv_we;
    logic [ADDR_BIT_WIDTH-1:0]   r_slv_addr;
    logic [DATA_BIT_WIDTH-1:0]   r_slv_wr_data;

    logic                        w_any;
    logic [2*N_MST-1:0]          w_rot;
    logic [c_ptr_w-1:0]          w_off;
    logic [c_ptr_w:0]            w_sum;
    logic [c_ptr_w-1:0]          w_sel;
    logic [c_ptr_w-1:0]          w_ptr_nxt;
    logic [c_cnt_w-1:0]          w_cnt_inc;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Rotate requests so that the pointer position lands at bit 0; the lowest
    // set bit of the rotated vector is the offset of the winner from the pointer.
    always_comb begin
        w_any = |i_mst_req;
        w_rot = {i_mst_req, i_mst_req} >> r_ptr;
        w_off = '0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = c_ptr_w'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_n_mst_ext) begin
            w_sum = w_sum - c_n_mst_ext;
        end
        w_sel     = w_sum[c_ptr_w-1:0];
        w_ptr_nxt = (w_sel == c_last_mst) ? '0 : w_sel + c_ptr_w'(1);
        w_cnt_inc = r_cnt + c_cnt_w'(1);
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_gnt         <= '0;
            r_rsp_vld     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_data    <= '0;
            r_slv_req     <= 1'b0;
            r_slv_we      <= 1'b0;
            r_slv_addr    <= '0;
            r_slv_wr_data <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_state       <= ST_BUSY;
                        r_sel         <= w_sel;
                        r_ptr         <= w_ptr_nxt;
                        r_gnt         <= c_one << w_sel;
                        r_slv_req     <= 1'b1;
                        r_slv_we      <= i_mst_we[w_sel];
                        r_slv_addr    <= i_mst_addr[int'(w_sel)*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH];
                        r_slv_wr_data <= i_mst_wr_data[int'(w_sel)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (i_slv_ack) begin
                        r_state    <= ST_RSP;
                        r_slv_req  <= 1'b0;
                        r_rsp_vld  <= c_one << r_sel;
                        r_rsp_err  <= 1'b0;
                        r_rsp_data <= r_slv_we ? '0 : i_slv_rd_data;
                        r_cnt      <= '0;
                    end else if (c_timeout_en && (w_cnt_inc == c_timeout)) begin
                        r_state    <= ST_RSP;
                        r_slv_req  <= 1'b0;
                        r_rsp_vld  <= c_one << r_sel;
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RSP: begin
                    r_state    <= ST_IDLE;
                    r_rsp_vld  <= '0;
                    r_rsp_err  <= 1'b0;
                    r_rsp_data <= '0;
                    r_cnt      <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mst_gnt     = r_gnt;
    assign o_mst_rsp_vld = r_rsp_vld;
    assign o_mst_rsp_err = r_rsp_err;
    assign o_mst_rd_data = r_rsp_data;
    assign o_slv_req     = r_slv_req;
    assign o_slv_we      = r_slv_we;
    assign o_slv_addr    = r_slv_addr;
    assign o_slv_wr_data = r_slv_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_simple_bus_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_bus_rr_arb
// Brief    : Directed self-checking bench for simple_bus_rr_arb (2 masters).
// Revision : 1.0
// ============================================================================
module tb_simple_bus_rr_arb;

    localparam int N_MST = 2;
    localparam int A_W   = 2;
    localparam int D_W   = 8;
    localparam int TO    = 15;

    logic                 clk;
    logic                 rst_n;
    logic [N_MST-1:0]     mst_req;
    logic [N_MST-1:0]     mst_we;
    logic [N_MST*A_W-1:0] mst_addr;
    logic [N_MST*D_W-1:0] mst_wr_data;
    logic [N_MST-1:0]     mst_gnt;
    logic [N_MST-1:0]     mst_rsp_vld;
    logic                 mst_rsp_err;
    logic [D_W-1:0]       mst_rd_data;
    logic                 slv_req;
    logic                 slv_we;
    logic [A_W-1:0]       slv_addr;
    logic [D_W-1:0]       slv_wr_data;
    logic                 slv_ack;
    logic [D_W-1:0]       slv_rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    simple_bus_rr_arb #(
        .N_MST          (N_MST),
        .ADDR_BIT_WIDTH (A_W),
        .DATA_BIT_WIDTH (D_W),
        .TIMEOUT_CYC    (TO)
    ) dut (
        .i_clk         (clk),
        .i_async_rst_n (rst_n),
        .i_mst_req     (mst_req),
        .i_mst_we      (mst_we),
        .i_mst_addr    (mst_addr),
        .i_mst_wr_data (mst_wr_data),
        .o_mst_gnt     (mst_gnt),
        .o_mst_rsp_vld (mst_rsp_vld),
        .o_mst_rsp_err (mst_rsp_err),
        .o_mst_rd_data (mst_rd_data),
        .o_slv_req     (slv_req),
        .o_slv_we      (slv_we),
        .o_slv_addr    (slv_addr),
        .o_slv_wr_data (slv_wr_data),
        .i_slv_ack     (slv_ack),
        .i_slv_rd_data (slv_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     32'(mst_gnt),     32'h0);
        check({tag, "_rsp_vld"}, 32'(mst_rsp_vld), 32'h0);
        check({tag, "_rsp_err"}, 32'(mst_rsp_err), 32'h0);
        check({tag, "_rd_data"}, 32'(mst_rd_data), 32'h0);
        check({tag, "_slv_req"}, 32'(slv_req),     32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random activity on the inputs
        rst_n       = 1'b0;
        mst_req     = N_MST'($urandom);
        mst_we      = N_MST'($urandom);
        mst_addr    = (N_MST*A_W)'($urandom);
        mst_wr_data = (N_MST*D_W)'($urandom);
        slv_ack     = 1'($urandom);
        slv_rd_data = D_W'($urandom);
        repeat (3) begin
            tick();
            mst_req = N_MST'($urandom);
            slv_ack = 1'($urandom);
        end
        check_all_zero("reset");
        check("reset_slv_we",   32'(slv_we),      32'h0);
        check("reset_slv_addr", 32'(slv_addr),    32'h0);
        check("reset_slv_wd",   32'(slv_wr_data), 32'h0);

        rst_n   = 1'b1;
        mst_req = '0;
        slv_ack = 1'b0;
        repeat (3) tick();
        check_all_zero("post_release");

        // Single read from master 0, addr 2, slave acks two cycles later with 0xA5
        mst_req  = 2'b01;
        mst_we   = 2'b00;
        mst_addr = {2'd0, 2'd2};
        tick();
        check("rd_gnt",      32'(mst_gnt),  32'h1);
        check("rd_slv_req",  32'(slv_req),  32'h1);
        check("rd_slv_addr", 32'(slv_addr), 32'h2);
        check("rd_slv_we",   32'(slv_we),   32'h0);
        mst_req = 2'b00;
        tick();
        check("rd_gnt_once", 32'(mst_gnt),     32'h0);
        check("rd_req_held", 32'(slv_req),     32'h1);
        check("rd_no_rsp",   32'(mst_rsp_vld), 32'h0);
        slv_ack     = 1'b1;
        slv_rd_data = 8'hA5;
        tick();
        slv_ack = 1'b0;
        check("rd_rsp_vld",  32'(mst_rsp_vld), 32'h1);
        check("rd_rsp_data", 32'(mst_rd_data), 32'hA5);
        check("rd_rsp_err",  32'(mst_rsp_err), 32'h0);
        check("rd_req_drop", 32'(slv_req),     32'h0);
        tick();
        check("rd_rsp_once", 32'(mst_rsp_vld), 32'h0);
        check("rd_data_clr", 32'(mst_rd_data), 32'h0);

        // Fairness: both masters request, slave acks immediately; pointer now at 1
        mst_req     = 2'b11;
        slv_ack     = 1'b1;
        slv_rd_data = 8'h11;
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("rr_gnt%0d", g), 32'(mst_gnt), (g % 2 == 0) ? 32'h2 : 32'h1);
            tick();
            check($sformatf("rr_rsp%0d", g), 32'(mst_rsp_vld), (g % 2 == 0) ? 32'h2 : 32'h1);
            tick();
            check($sformatf("rr_idle%0d", g), 32'({mst_gnt, mst_rsp_vld}), 32'h0);
        end
        mst_req = 2'b00;
        slv_ack = 1'b0;

        // Write from master 1 (pointer at 1), captured read data must be 0
        mst_req     = 2'b10;
        mst_we      = 2'b10;
        mst_addr    = {2'd3, 2'd0};
        mst_wr_data = {8'h3C, 8'h00};
        tick();
        check("wr_gnt",     32'(mst_gnt),     32'h2);
        check("wr_slv_we",  32'(slv_we),      32'h1);
        check("wr_slv_adr", 32'(slv_addr),    32'h3);
        check("wr_slv_wd",  32'(slv_wr_data), 32'h3C);
        mst_req     = 2'b00;
        slv_ack     = 1'b1;
        slv_rd_data = 8'hFF;
        tick();
        slv_ack = 1'b0;
        check("wr_rsp_vld",  32'(mst_rsp_vld), 32'h2);
        check("wr_rsp_data", 32'(mst_rd_data), 32'h0);
        check("wr_rsp_err",  32'(mst_rsp_err), 32'h0);
        tick();

        // Timeout: master 0 read, never acked
        mst_req     = 2'b01;
        mst_we      = 2'b00;
        mst_addr    = {2'd0, 2'd1};
        slv_rd_data = 8'h77;
        tick();
        check("to_gnt", 32'(mst_gnt), 32'h1);
        mst_req = 2'b00;
        for (int k = 1; k < TO; k++) begin
            tick();
            check($sformatf("to_req_held%0d", k), 32'(slv_req), 32'h1);
        end
        tick();
        check("to_req_drop", 32'(slv_req),     32'h0);
        check("to_rsp_vld",  32'(mst_rsp_vld), 32'h1);
        check("to_rsp_err",  32'(mst_rsp_err), 32'h1);
        check("to_rsp_data", 32'(mst_rd_data), 32'h0);
        tick();
        check("to_err_clr",  32'(mst_rsp_err), 32'h0);
        check("to_vld_clr",  32'(mst_rsp_vld), 32'h0);

        // Ack on the 15th BUSY cycle: ack wins over timeout (master 1, pointer at 1)
        mst_req = 2'b10;
        tick();
        check("ak_gnt", 32'(mst_gnt), 32'h2);
        mst_req = 2'b00;
        repeat (TO - 2) tick();
        tick();
        check("ak_req_held", 32'(slv_req), 32'h1);
        slv_ack     = 1'b1;
        slv_rd_data = 8'h5A;
        tick();
        slv_ack = 1'b0;
        check("ak_rsp_vld",  32'(mst_rsp_vld), 32'h2);
        check("ak_rsp_err",  32'(mst_rsp_err), 32'h0);
        check("ak_rsp_data", 32'(mst_rd_data), 32'h5A);
        tick();

        // Reset mid-BUSY with pointer advanced to 1
        mst_req = 2'b01;
        tick();
        check("mr_gnt",     32'(mst_gnt), 32'h1);
        check("mr_slv_req", 32'(slv_req), 32'h1);
        mst_req = 2'b00;
        #2;
        rst_n   = 1'b0;
        slv_ack = 1'b1;
        #1;
        check_all_zero("mr_async");
        repeat (2) begin
            tick();
            check("mr_no_rsp", 32'(mst_rsp_vld), 32'h0);
        end
        rst_n   = 1'b1;
        slv_ack = 1'b0;
        repeat (3) tick();
        check("mr_still_no_rsp", 32'(mst_rsp_vld), 32'h0);
        mst_req = 2'b11;
        tick();
        check("mr_gnt_m0",  32'(mst_gnt), 32'h1);
        check("mr_req_new", 32'(slv_req), 32'h1);
        mst_req     = 2'b00;
        slv_ack     = 1'b1;
        slv_rd_data = 8'hC3;
        tick();
        slv_ack = 1'b0;
        check("mr_rsp_vld",  32'(mst_rsp_vld), 32'h1);
        check("mr_rsp_data", 32'(mst_rd_data), 32'hC3);
        tick();
        check_all_zero("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
